// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the arbitrated Gray-to-binary datapath.
// The stage record is sized for the widest supported configuration.
package gray_conv_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_ID_W   = 4;

  // Requester tag width; a single requester still gets a 1-bit tag.
  function automatic int calc_id_w(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [MAX_ID_W-1:0]   id;
    logic [MAX_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at and above it.
module gray2bin_comb #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    acc = 1'b0;
    bin = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared two-stage Gray-to-binary pipeline;
// results leave on a single valid/ready port tagged with the requester index.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_REQ    = 4,
  localparam int ID_W       = calc_id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gray,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_bin,
  output logic [ID_W-1:0]               out_id
);

  logic [DATA_WIDTH-1:0] gray_p0 [NUM_REQ];
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       rr_nxt;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       idx;
  logic                  gnt_any;
  logic                  take_p0;
  logic                  s1_load;
  logic                  s2_load;
  logic [DATA_WIDTH-1:0] bin_p1;
  stage_t                st_p1;
  stage_t                st_p2;
  logic                  unused_hi;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign gray_p0[r] = req_gray[r*DATA_WIDTH +: DATA_WIDTH];
  end

  // p0: round-robin search starting at rr_ptr
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign rr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  assign s2_load = !st_p2.valid || (out_valid && out_ready);
  assign s1_load = !st_p1.valid || s2_load;
  // Reset gates ready combinationally so no handshake completes while held.
  assign take_p0 = resetn && gnt_any && s1_load;

  always_comb begin
    req_ready = '0;
    if (take_p0) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  gray2bin_comb #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gray2bin (
    .gray (st_p1.data[DATA_WIDTH-1:0]),
    .bin  (bin_p1)
  );

  // p0 -> p1 -> p2 register stages
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
      st_p1  <= '0;
      st_p2  <= '0;
    end else begin
      if (take_p0) begin
        rr_ptr     <= rr_nxt;
        st_p1.id   <= MAX_ID_W'(gnt_id);
        st_p1.data <= MAX_DATA_W'(gray_p0[gnt_id]);
      end
      if (s1_load) begin
        st_p1.valid <= take_p0;
      end
      if (s2_load) begin
        st_p2.valid <= st_p1.valid;
        if (st_p1.valid) begin
          st_p2.id   <= st_p1.id;
          st_p2.data <= MAX_DATA_W'(bin_p1);
        end
      end
    end
  end

  assign out_valid = st_p2.valid;
  assign out_bin   = st_p2.data[DATA_WIDTH-1:0];
  assign out_id    = st_p2.id[ID_W-1:0];

  // Record bits above this instance's widths are always zero and never read.
  assign unused_hi = ^{st_p1.id, st_p1.data, st_p2.id, st_p2.data};

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: a 16-bit four-requester instance and
// an 8-bit single-requester instance sharing clock and reset.
module tb_gray_conv_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [NR-1:0]     rv;
  logic [NR*DW-1:0]  rg;
  logic [NR-1:0]     rr;
  logic              ov;
  logic              ordy;
  logic [DW-1:0]     ob;
  logic [1:0]        oid;

  logic [0:0]        rv8;
  logic [7:0]        rg8;
  logic [0:0]        rr8;
  logic              ov8;
  logic              ordy8;
  logic [7:0]        ob8;
  logic [0:0]        oid8;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] t2_bin [4] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
  logic [15:0] t3_bin [4] = '{16'h0006, 16'h000A, 16'h0080, 16'hAAAA};
  logic [3:0]  t3_gnt [5] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

  gray_conv_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (rv),
    .req_gray  (rg),
    .req_ready (rr),
    .out_valid (ov),
    .out_ready (ordy),
    .out_bin   (ob),
    .out_id    (oid)
  );

  gray_conv_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (1)
  ) u_dut8 (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (rv8),
    .req_gray  (rg8),
    .req_ready (rr8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_bin   (ob8),
    .out_id    (oid8)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rv     = '0;
    ordy   = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] acc;
    int            n_acc;
    int            sent;
    int            rcv;
    logic          go;

    resetn = 1'b1;
    rv     = 4'hF;
    rg     = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    ordy   = 1'b1;
    rv8    = 1'b0;
    rg8    = 8'h00;
    ordy8  = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk_eq("rst_ready", 32'(rr), 0);
    chk_eq("rst_valid", 32'(ov), 0);
    chk_eq("rst_bin", 32'(ob), 0);
    chk_eq("rst_id", 32'(oid), 0);
    chk_eq("rst_valid8", 32'(ov8), 0);
    tick();

    // single request, two-cycle latency
    do_reset();
    rg[2*DW +: DW] = 16'h8001;
    rv = 4'b0100;
    #1 chk_eq("t1_ready", 32'(rr), 32'(4'b0100));
    tick();
    rv = '0;
    #1 chk_eq("t1_n1_valid", 32'(ov), 0);
    tick();
    #1;
    chk_eq("t1_valid", 32'(ov), 1);
    chk_eq("t1_bin", 32'(ob), 'hFFFE);
    chk_eq("t1_id", 32'(oid), 2);
    tick();

    // all four requesters at once after reset
    do_reset();
    rg = {16'h8000, 16'h0003, 16'h0001, 16'h0000};
    rv = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 4) chk_eq($sformatf("t2_gnt%0d", k), 32'(rr), 32'(1 << k));
      if (k >= 2) begin
        chk_eq($sformatf("t2_valid%0d", k), 32'(ov), 1);
        chk_eq($sformatf("t2_id%0d", k), 32'(oid), 32'(k - 2));
        chk_eq($sformatf("t2_bin%0d", k), 32'(ob), 32'(t2_bin[k-2]));
      end
      acc = rr;
      tick();
      rv = rv & ~acc;
    end

    // backpressure: only two words fit
    do_reset();
    ordy  = 1'b0;
    rg    = {16'hFFFF, 16'h00C0, 16'h000F, 16'h0005};
    rv    = 4'hF;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rr != '0) n_acc++;
      if (k == 5) begin
        chk_eq("t3_ready_held", 32'(rr), 0);
        chk_eq("t3_valid_held", 32'(ov), 1);
        chk_eq("t3_id_held", 32'(oid), 0);
        chk_eq("t3_bin_held", 32'(ob), 'h0006);
      end
      acc = rr;
      tick();
      rv = rv & ~acc;
    end
    chk_eq("t3_accepted", n_acc, 2);
    ordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 4) begin
        chk_eq($sformatf("t3_valid%0d", k), 32'(ov), 1);
        chk_eq($sformatf("t3_id%0d", k), 32'(oid), 32'(k));
        chk_eq($sformatf("t3_bin%0d", k), 32'(ob), 32'(t3_bin[k]));
      end else begin
        chk_eq("t3_drained", 32'(ov), 0);
      end
      chk_eq($sformatf("t3_gnt%0d", k), 32'(rr), 32'(t3_gnt[k]));
      acc = rr;
      tick();
      rv = rv & ~acc;
    end

    // fairness between requesters 1 and 3
    do_reset();
    rv = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      #1 chk_eq($sformatf("t4_gnt%0d", k), 32'(rr), (k % 2 == 0) ? 32'(4'b0010) : 32'(4'b1000));
      tick();
    end

    // reset with both stages full
    #1 chk_eq("t5_full", 32'(ov), 1);
    resetn = 1'b0;
    #1;
    chk_eq("t5_valid", 32'(ov), 0);
    chk_eq("t5_ready", 32'(rr), 0);
    chk_eq("t5_bin", 32'(ob), 0);
    chk_eq("t5_id", 32'(oid), 0);
    tick();
    tick();
    resetn = 1'b1;
    #1 chk_eq("t5_first_gnt", 32'(rr), 32'(4'b0010));
    rv = '0;
    tick();

    // exhaustive 8-bit conversion through the single-requester instance
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 300 && rcv < 256; c++) begin
      rv8 = (sent < 256) ? 1'b1 : 1'b0;
      rg8 = 8'(sent ^ (sent >> 1));
      #1;
      if (ov8) begin
        chk_eq($sformatf("t6_bin%0d", rcv), 32'(ob8), 32'(rcv));
        chk_eq("t6_id", 32'(oid8), 0);
        rcv++;
      end
      go = rv8[0] & rr8[0];
      tick();
      if (go) sent++;
    end
    chk_eq("t6_count", rcv, 256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
